// File: rtl/chip8_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip8_loader_pkg
// Description : Shared state encoding and default constants for the CHIP-8
//               program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package chip8_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Default frame / memory constants
    localparam logic [11:0] c_LOAD_BASE = 12'h200;
    localparam int          c_MAX_LEN   = 3584;
    localparam logic [7:0]  c_SYNC_BYTE = 8'hA5;
    localparam logic [23:0] c_TIMEOUT   = 24'd1000000;

    // True while a frame is being received (inter-byte timer is running)
    function automatic logic in_frame(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA)   || (s == ST_CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : chip8_loader_if
// Description : Byte stream input and RAM/CPU-control outputs of the loader.
//               slave = loader side, master = UART/RAM/CPU side.
// Revision    : 1.0 - initial release
// ============================================================================
interface chip8_loader_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [11:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        mem_we_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;

    modport slave (
        input  rx_data_i, rx_valid_i,
        output mem_addr_o, mem_data_o, mem_we_o, cpu_rst_o, done_o, err_o
    );

    modport master (
        output rx_data_i, rx_valid_i,
        input  mem_addr_o, mem_data_o, mem_we_o, cpu_rst_o, done_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/chip8_loader_timer.sv
`default_nettype none
// ============================================================================
// Module      : chip8_loader_timer
// Description : Inter-byte timeout counter. Clear has priority over enable;
//               the count saturates at TIMEOUT and flags expiry there.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_loader_timer #(
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_expired
);

    logic [23:0] r_count;

    // Count idle cycles; restart on every received byte
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= 24'd0;
        end else if (i_clr) begin
            r_count <= 24'd0;
        end else if (i_en && (r_count != TIMEOUT)) begin
            r_count <= r_count + 24'd1;
        end
    end

    assign o_expired = (r_count == TIMEOUT);

endmodule
`default_nettype wire

// File: rtl/chip8_loader.sv
`default_nettype none
// ============================================================================
// Module      : chip8_loader
// Description : Parses SYNC/LEN/payload/CSUM frames from the UART byte stream,
//               writes the payload into CHIP-8 RAM from LOAD_BASE and holds
//               the core in reset until the checksum verifies.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_loader
    import chip8_loader_pkg::*;
#(
    parameter logic [11:0] LOAD_BASE = c_LOAD_BASE,
    parameter int          MAX_LEN   = c_MAX_LEN,
    parameter logic [7:0]  SYNC_BYTE = c_SYNC_BYTE,
    parameter logic [23:0] TIMEOUT   = c_TIMEOUT
) (
    input  wire logic      clk_i,
    input  wire logic      rst_i,
    chip8_loader_if.slave  bus
);

    state_t      r_state,   w_state;
    logic [15:0] r_len,     w_len;
    logic [15:0] r_idx,     w_idx;
    logic [7:0]  r_csum,    w_csum;
    logic [11:0] r_addr,    w_addr;
    logic [7:0]  r_data,    w_data;
    logic        r_we,      w_we;
    logic        r_cpu_rst, w_cpu_rst;
    logic        r_done,    w_done;
    logic        r_err,     w_err;

    logic        w_expired;
    logic        w_in_frame;
    logic [15:0] w_len_full;
    logic [15:0] w_idx_inc;

    assign w_in_frame = in_frame(r_state);
    assign w_len_full = {r_len[15:8], bus.rx_data_i};
    assign w_idx_inc  = r_idx + 16'd1;

    chip8_loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_clr     (bus.rx_valid_i || !w_in_frame),
        .i_en      (w_in_frame),
        .o_expired (w_expired)
    );

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_len     <= 16'd0;
            r_idx     <= 16'd0;
            r_csum    <= 8'd0;
            r_addr    <= 12'd0;
            r_data    <= 8'd0;
            r_we      <= 1'b0;
            r_cpu_rst <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_len     <= w_len;
            r_idx     <= w_idx;
            r_csum    <= w_csum;
            r_addr    <= w_addr;
            r_data    <= w_data;
            r_we      <= w_we;
            r_cpu_rst <= w_cpu_rst;
            r_done    <= w_done;
            r_err     <= w_err;
        end
    end

    // Next-state and output decode; a received byte always beats the timeout
    always_comb begin
        w_state   = r_state;
        w_len     = r_len;
        w_idx     = r_idx;
        w_csum    = r_csum;
        w_addr    = r_addr;
        w_data    = r_data;
        w_we      = 1'b0;
        w_cpu_rst = r_cpu_rst;
        w_done    = r_done;
        w_err     = r_err;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.rx_valid_i && (bus.rx_data_i == SYNC_BYTE)) begin
                    w_state   = ST_LEN_HI;
                    w_cpu_rst = 1'b1;
                    w_done    = 1'b0;
                    w_err     = 1'b0;
                end
            end
            ST_LEN_HI: begin
                if (bus.rx_valid_i) begin
                    w_len[15:8] = bus.rx_data_i;
                    w_state     = ST_LEN_LO;
                end else if (w_expired) begin
                    w_state = ST_ERR;
                    w_err   = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (bus.rx_valid_i) begin
                    w_len = w_len_full;
                    if ((w_len_full == 16'd0) || (w_len_full > 16'(MAX_LEN))) begin
                        w_state = ST_ERR;
                        w_err   = 1'b1;
                    end else begin
                        w_idx   = 16'd0;
                        w_csum  = 8'd0;
                        w_state = ST_DATA;
                    end
                end else if (w_expired) begin
                    w_state = ST_ERR;
                    w_err   = 1'b1;
                end
            end
            ST_DATA: begin
                if (bus.rx_valid_i) begin
                    w_data = bus.rx_data_i;
                    w_addr = LOAD_BASE + r_idx[11:0];
                    w_we   = 1'b1;
                    w_csum = r_csum + bus.rx_data_i;
                    w_idx  = w_idx_inc;
                    if (w_idx_inc == r_len) begin
                        w_state = ST_CSUM;
                    end
                end else if (w_expired) begin
                    w_state = ST_ERR;
                    w_err   = 1'b1;
                end
            end
            ST_CSUM: begin
                if (bus.rx_valid_i) begin
                    if (bus.rx_data_i == r_csum) begin
                        w_state   = ST_DONE;
                        w_done    = 1'b1;
                        w_cpu_rst = 1'b0;
                    end else begin
                        w_state = ST_ERR;
                        w_err   = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state = ST_ERR;
                    w_err   = 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_addr_o = r_addr;
    assign bus.mem_data_o = r_data;
    assign bus.mem_we_o   = r_we;
    assign bus.cpu_rst_o  = r_cpu_rst;
    assign bus.done_o     = r_done;
    assign bus.err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_chip8_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_loader
// Description : Self-checking bench for chip8_loader: directed frames plus
//               randomized frames checked against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   npass  = 0;
    int   ntotal = 0;

    wr_t  got_wr[$];
    wr_t  exp_wr[$];
    logic exp_done;
    logic exp_err;

    chip8_loader_if bus();

    chip8_loader #(
        .TIMEOUT (24'd100)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Capture every RAM write pulse
    always @(negedge clk) begin
        if (bus.mem_we_o === 1'b1)
            got_wr.push_back('{a: bus.mem_addr_o, d: bus.mem_data_o});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal = ntotal + 1;
        assert (obs === exp) npass = npass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input bq_t q, input int gap);
        foreach (q[i]) begin
            @(negedge clk);
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = q[i];
            repeat (gap) begin
                @(negedge clk);
                bus.rx_valid_i = 1'b0;
            end
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
    endtask

    // Frame-level reference: decode the byte list directly from the format rules
    task automatic model(input bq_t f);
        int unsigned len;
        int unsigned sum;
        exp_wr.delete();
        len = {f[1], f[2]};
        if (len == 0 || len > 3584) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end else begin
            sum = 0;
            for (int i = 0; i < int'(len); i++) begin
                exp_wr.push_back('{a: 12'((32'h200 + i) % 4096), d: f[3 + i]});
                sum = sum + f[3 + i];
            end
            exp_done = (f[3 + len] == 8'(sum % 256));
            exp_err  = !exp_done;
        end
    endtask

    task automatic check_frame(input string tag);
        int n;
        repeat (2) @(negedge clk);
        check({tag, "_nwr"}, got_wr.size(), exp_wr.size());
        n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, 32'(got_wr[i].a), 32'(exp_wr[i].a));
            check({tag, "_data"}, 32'(got_wr[i].d), 32'(exp_wr[i].d));
        end
        check({tag, "_done"}, 32'(bus.done_o), 32'(exp_done));
        check({tag, "_err"}, 32'(bus.err_o), 32'(exp_err));
        check({tag, "_cpu_rst"}, 32'(bus.cpu_rst_o), 32'(exp_err));
        got_wr.delete();
    endtask

    function automatic bq_t make_frame(input int len, input bit bad);
        bq_t f;
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        f.push_back(8'hA5);
        f.push_back(8'(len >> 8));
        f.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            s = s + b;
        end
        f.push_back(bad ? (s ^ 8'h01) : s);
        return f;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(bus.mem_addr_o), 32'h0);
        check({tag, "_data"}, 32'(bus.mem_data_o), 32'h0);
        check({tag, "_we"}, 32'(bus.mem_we_o), 32'h0);
        check({tag, "_cpu_rst"}, 32'(bus.cpu_rst_o), 32'h0);
        check({tag, "_done"}, 32'(bus.done_o), 32'h0);
        check({tag, "_err"}, 32'(bus.err_o), 32'h0);
    endtask

    initial begin
        bq_t f;
        bq_t junk;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        got_wr.delete();

        // Good frame
        f = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        model(f); send(f, 1); check_frame("good3");

        // Bad checksum
        f = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
        model(f); send(f, 1); check_frame("badcsum");

        // Zero length
        f = '{8'hA5, 8'h00, 8'h00};
        model(f); send(f, 1); check_frame("len0");

        // Length one past the maximum
        f = '{8'hA5, 8'h0E, 8'h01};
        model(f); send(f, 1); check_frame("len3585");

        // Timeout mid-payload
        f = '{8'hA5, 8'h00, 8'h02, 8'h11};
        send(f, 1);
        repeat (50) @(negedge clk);
        check("tmo_early_err", 32'(bus.err_o), 32'h0);
        check("tmo_early_cpu_rst", 32'(bus.cpu_rst_o), 32'h1);
        repeat (60) @(negedge clk);
        exp_wr.delete();
        exp_wr.push_back('{a: 12'h200, d: 8'h11});
        exp_done = 1'b0;
        exp_err  = 1'b1;
        check_frame("timeout");

        f = '{8'hA5, 8'h00, 8'h01, 8'h7F, 8'h7F};
        model(f); send(f, 2); check_frame("after_tmo");

        // Back-to-back strobes with SYNC value inside the payload
        f = '{8'hA5, 8'h00, 8'h02, 8'hA5, 8'h01, 8'hA6};
        model(f); send(f, 0); check_frame("b2b");

        // Reset mid-frame
        f = '{8'hA5, 8'h00, 8'h05, 8'h12};
        send(f, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        got_wr.delete();
        f = '{8'hA5, 8'h00, 8'h01, 8'h09, 8'h09};
        model(f); send(f, 1); check_frame("after_rst");

        // Largest accepted payload fills RAM up to 0xFFF
        f = make_frame(3584, 1'b0);
        model(f); send(f, 0); check_frame("maxlen");

        // Randomized frames with idle junk, random gaps and random corruption
        for (int k = 0; k < 12; k++) begin
            junk.delete();
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                logic [7:0] jb;
                jb = 8'($urandom);
                if (jb == 8'hA5) jb = 8'h5A;
                junk.push_back(jb);
            end
            send(junk, 0);
            f = make_frame(int'($urandom_range(1, 24)), ($urandom_range(0, 2) == 0));
            model(f);
            send(f, int'($urandom_range(0, 2)));
            check_frame("rand");
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
`default_nettype wire
